// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI4 constants, scheduler state type and helpers
package axi_pkg;

    localparam int AXI_ID_W   = 4;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_LEN_W  = 8;
    localparam int AXI_DATA_W = 64;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [3:0] AXCACHE_DEFAULT = 4'b0011;
    localparam logic [2:0] AXPROT_DEFAULT  = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R
    } sched_state_e;

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_rr_arb2.sv
// rtl/axi_rr_arb2.sv - two-requester round-robin arbiter, write wins the first tie after reset
module axi_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_w_i,
    input  logic       req_r_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    logic last_read_q;
    logic last_read_d;

    always_comb begin
        grant_o     = 2'b00;
        last_read_d = last_read_q;
        if (req_w_i && req_r_i) begin
            grant_o = last_read_q ? 2'b01 : 2'b10;
        end else if (req_w_i) begin
            grant_o = 2'b01;
        end else if (req_r_i) begin
            grant_o = 2'b10;
        end
        if (accept_i && (grant_o != 2'b00)) begin
            last_read_d = grant_o[1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_read_q <= 1'b1;
        end else begin
            last_read_q <= last_read_d;
        end
    end

endmodule

// File: rtl/axi_burst_sched.sv
// rtl/axi_burst_sched.sv - single-outstanding AXI4 burst scheduler for the LPDDR path
module axi_burst_sched
    import axi_pkg::*;
#(
    parameter int ID_W   = AXI_ID_W,
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int LEN_W  = AXI_LEN_W,
    parameter int DATA_W = AXI_DATA_W
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                wc_valid,
    output logic                wc_ready,
    input  logic [ID_W-1:0]     wc_id,
    input  logic [ADDR_W-1:0]   wc_addr,
    input  logic [LEN_W-1:0]    wc_len,
    input  logic                rc_valid,
    output logic                rc_ready,
    input  logic [ID_W-1:0]     rc_id,
    input  logic [ADDR_W-1:0]   rc_addr,
    input  logic [LEN_W-1:0]    rc_len,
    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [DATA_W-1:0]   wd_data,
    input  logic [DATA_W/8-1:0] wd_strb,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_last,
    output logic                done_valid,
    output logic                done_write,
    output logic [ID_W-1:0]     done_id,
    output logic [1:0]          done_resp,
    output logic [ID_W-1:0]     awid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [LEN_W-1:0]    awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awlock,
    output logic [3:0]          awcache,
    output logic [2:0]          awprot,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [ID_W-1:0]     bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic [ID_W-1:0]     arid,
    output logic [ADDR_W-1:0]   araddr,
    output logic [LEN_W-1:0]    arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic                arlock,
    output logic [3:0]          arcache,
    output logic [2:0]          arprot,
    output logic                arvalid,
    input  logic                arready,
    input  logic [ID_W-1:0]     rid,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready
);

    localparam logic [2:0] AXSIZE = 3'($clog2(DATA_W / 8));

    sched_state_e      state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [1:0]        resp_q, resp_d;
    logic [1:0]        grant;

    axi_rr_arb2 u_arb (
        .clk_i    (aclk),
        .rst_i    (areset),
        .req_w_i  (wc_valid),
        .req_r_i  (rc_valid),
        .accept_i (state_q == S_IDLE),
        .grant_o  (grant)
    );

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_d     = beat_q;
        resp_d     = resp_q;
        wc_ready   = 1'b0;
        rc_ready   = 1'b0;
        wd_ready   = 1'b0;
        wvalid     = 1'b0;
        wlast      = 1'b0;
        bready     = 1'b0;
        rready     = 1'b0;
        rd_valid   = 1'b0;
        rd_last    = 1'b0;
        done_valid = 1'b0;
        done_write = 1'b0;
        done_resp  = RESP_OKAY;
        unique case (state_q)
            S_IDLE: begin
                wc_ready = grant[0];
                rc_ready = grant[1];
                if (grant[0]) begin
                    id_d    = wc_id;
                    addr_d  = wc_addr;
                    len_d   = wc_len;
                    state_d = S_AW;
                end else if (grant[1]) begin
                    id_d    = rc_id;
                    addr_d  = rc_addr;
                    len_d   = rc_len;
                    state_d = S_AR;
                end
                if (grant != 2'b00) begin
                    beat_d = '0;
                    resp_d = RESP_OKAY;
                end
            end
            S_AW: if (awready) state_d = S_W;
            S_W: begin
                wvalid   = wd_valid;
                wd_ready = wready;
                wlast    = (beat_q == len_q);
                if (wd_valid && wready) begin
                    if (wlast) state_d = S_B;
                    else       beat_d  = beat_q + LEN_W'(1);
                end
            end
            S_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    done_valid = 1'b1;
                    done_write = 1'b1;
                    done_resp  = (bid != id_q) ? RESP_SLVERR : bresp;
                    state_d    = S_IDLE;
                end
            end
            S_AR: if (arready) state_d = S_R;
            S_R: begin
                rready   = rd_ready;
                rd_valid = rvalid;
                rd_last  = rlast;
                if (rvalid && rd_ready) begin
                    resp_d = resp_max(resp_q, rresp);
                    // Slave may overrun len; the count saturates instead of wrapping.
                    if (beat_q != '1) beat_d = beat_q + LEN_W'(1);
                    if (rlast) begin
                        done_valid = 1'b1;
                        done_resp  = (rid != id_q) ? RESP_SLVERR : resp_max(resp_q, rresp);
                        state_d    = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            resp_q  <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            resp_q  <= resp_d;
        end
    end

    assign done_id = id_q;
    assign rd_data = rdata;
    assign wdata   = wd_data;
    assign wstrb   = wd_strb;

    assign awvalid = (state_q == S_AW);
    assign awid    = id_q;
    assign awaddr  = addr_q;
    assign awlen   = len_q;
    assign awsize  = AXSIZE;
    assign awburst = BURST_INCR;
    assign awlock  = 1'b0;
    assign awcache = AXCACHE_DEFAULT;
    assign awprot  = AXPROT_DEFAULT;

    assign arvalid = (state_q == S_AR);
    assign arid    = id_q;
    assign araddr  = addr_q;
    assign arlen   = len_q;
    assign arsize  = AXSIZE;
    assign arburst = BURST_INCR;
    assign arlock  = 1'b0;
    assign arcache = AXCACHE_DEFAULT;
    assign arprot  = AXPROT_DEFAULT;

endmodule

// File: tb/tb_axi_burst_sched.sv
// tb/tb_axi_burst_sched.sv - randomized self-checking bench for axi_burst_sched
module tb_axi_burst_sched;

    localparam int ID_W = 4, ADDR_W = 32, LEN_W = 8, DATA_W = 64, SW = DATA_W / 8;

    typedef struct {
        int acc_wait; int addr_bad; int beats; int last_pos; int first_cyc; int data_bad; int dones;
        logic d_write; logic [ID_W-1:0] d_id; logic [1:0] d_resp;
    } res_t;

    logic aclk = 1'b0;
    logic areset;
    logic wc_valid, wc_ready, rc_valid, rc_ready;
    logic [ID_W-1:0] wc_id, rc_id, done_id, awid, arid, bid, rid;
    logic [ADDR_W-1:0] wc_addr, rc_addr, awaddr, araddr;
    logic [LEN_W-1:0] wc_len, rc_len, awlen, arlen;
    logic wd_valid, wd_ready, rd_valid, rd_ready, rd_last;
    logic [DATA_W-1:0] wd_data, rd_data, wdata, rdata;
    logic [SW-1:0] wd_strb, wstrb;
    logic done_valid, done_write;
    logic [1:0] done_resp, bresp, rresp, awburst, arburst;
    logic [2:0] awsize, arsize, awprot, arprot;
    logic [3:0] awcache, arcache;
    logic awlock, arlock, awvalid, awready, arvalid, arready;
    logic wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    axi_burst_sched dut (
        .aclk(aclk), .areset(areset),
        .wc_valid(wc_valid), .wc_ready(wc_ready), .wc_id(wc_id), .wc_addr(wc_addr), .wc_len(wc_len),
        .rc_valid(rc_valid), .rc_ready(rc_ready), .rc_id(rc_id), .rc_addr(rc_addr), .rc_len(rc_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done_valid(done_valid), .done_write(done_write), .done_id(done_id), .done_resp(done_resp),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
        .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    task automatic clear_inputs();
        wc_valid = 0; wc_id = 0; wc_addr = 0; wc_len = 0;
        rc_valid = 0; rc_id = 0; rc_addr = 0; rc_len = 0;
        wd_valid = 0; wd_data = 0; wd_strb = 0; rd_ready = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    endtask

    task automatic accept_cmd(input bit is_rd, input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                              input logic [LEN_W-1:0] len, output int waited);
        waited = 0;
        if (is_rd) begin rc_valid = 1; rc_id = id; rc_addr = addr; rc_len = len; end
        else       begin wc_valid = 1; wc_id = id; wc_addr = addr; wc_len = len; end
        #1;
        while (!(is_rd ? rc_ready : wc_ready) && waited < 50) begin
            @(negedge aclk); #1; waited++;
        end
        @(negedge aclk);
        wc_valid = 0; rc_valid = 0;
    endtask

    // Data is offered on both sides during the address phase; none of it may reach the fabric yet.
    task automatic addr_phase(input bit is_rd, input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                              input logic [LEN_W-1:0] len, input int stall, output int bad);
        bad = 0;
        for (int k = 0; k <= stall; k++) begin
            awready = !is_rd && (k == stall);
            arready = is_rd && (k == stall);
            wd_valid = 1; wready = 1; rvalid = 1; rd_ready = 1;
            #1;
            if (is_rd) begin
                if (!arvalid || awvalid || araddr !== addr || arid !== id || arlen !== len) bad++;
            end else if (!awvalid || arvalid || awaddr !== addr || awid !== id || awlen !== len) bad++;
            if (wvalid || wd_ready || rd_valid || rready || done_valid) bad++;
            @(negedge aclk);
        end
        awready = 0; arready = 0; wd_valid = 0; wready = 0; rvalid = 0; rd_ready = 0;
    endtask

    task automatic write_cmd(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                             input logic [ID_W-1:0] b_id, input logic [1:0] b_resp, input int stall,
                             input bit rand_hs, output res_t r);
        int n;
        r = '{default: 0};
        r.first_cyc = -1;
        accept_cmd(0, id, addr, len, r.acc_wait);
        addr_phase(0, id, addr, len, stall, r.addr_bad);
        n = 0;
        while (r.last_pos == 0 && n < 3000) begin
            wd_valid = rand_hs ? 1'($urandom_range(0, 1)) : 1'b1;
            wready   = rand_hs ? 1'($urandom_range(0, 1)) : 1'b1;
            wd_data  = {$urandom, $urandom};
            wd_strb  = SW'($urandom);
            #1;
            if (wvalid !== wd_valid || wd_ready !== wready || wdata !== wd_data || wstrb !== wd_strb) r.data_bad++;
            if (done_valid) r.dones++;
            if (wd_valid && wready) begin
                r.beats++;
                if (r.first_cyc < 0) r.first_cyc = n;
                if (wlast) r.last_pos = r.beats;
            end
            @(negedge aclk); n++;
        end
        wd_valid = 0; wready = 0; bvalid = 1; bid = b_id; bresp = b_resp;
        #1;
        if (!bready) r.data_bad++;
        if (done_valid) begin
            r.dones++; r.d_write = done_write; r.d_id = done_id; r.d_resp = done_resp;
        end
        @(negedge aclk);
        bvalid = 0;
        #1;
        if (done_valid) r.dones++;
    endtask

    task automatic read_cmd(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                            input logic [ID_W-1:0] r_id, input logic [1023:0] rv, input int nbeats, input int stall,
                            input bit rand_hs, output res_t r);
        int n, idx;
        r = '{default: 0};
        r.first_cyc = -1;
        accept_cmd(1, id, addr, len, r.acc_wait);
        addr_phase(1, id, addr, len, stall, r.addr_bad);
        n = 0; idx = 0;
        while (idx < nbeats && n < 3000) begin
            rvalid   = rand_hs ? 1'($urandom_range(0, 1)) : 1'b1;
            rd_ready = rand_hs ? 1'($urandom_range(0, 1)) : 1'b1;
            rdata    = {$urandom, $urandom};
            rresp    = rv[2*idx +: 2];
            rlast    = (idx == nbeats - 1);
            rid      = r_id;
            #1;
            if (rd_valid !== rvalid || rready !== rd_ready || rd_data !== rdata || rd_last !== rlast) r.data_bad++;
            if (rvalid && rd_ready) begin
                r.beats++; idx++;
                if (r.first_cyc < 0) r.first_cyc = n;
                if (rd_last) r.last_pos = r.beats;
                if (done_valid) begin
                    r.dones++; r.d_write = done_write; r.d_id = done_id; r.d_resp = done_resp;
                end
            end else if (done_valid) r.dones++;
            @(negedge aclk); n++;
        end
        rvalid = 0; rlast = 0; rd_ready = 0;
        #1;
        if (done_valid) r.dones++;
    endtask

    task automatic test_reset();
        clear_inputs();
        areset = 1;
        wd_valid = 1; wready = 1; bvalid = 1; rvalid = 1; rlast = 1; rd_ready = 1;
        repeat (3) @(negedge aclk);
        areset = 0;
        #1;
        checks++;
        if ({awvalid, arvalid, wvalid, wd_ready, wlast, bready, rready, rd_valid, rd_last, done_valid} !== 10'b0) begin
            errors++; $display("FAIL reset_valids: got %b required 0",
                {awvalid, arvalid, wvalid, wd_ready, wlast, bready, rready, rd_valid, rd_last, done_valid});
        end
        checks++;
        if ({awid, awaddr, awlen, arid, araddr, arlen} !== '0) begin
            errors++; $display("FAIL reset_fields: got aw %h/%h/%h ar %h/%h/%h required 0",
                awid, awaddr, awlen, arid, araddr, arlen);
        end
        checks++;
        if ({awsize, awburst, awlock, awcache, awprot} !== {3'd3, 2'b01, 1'b0, 4'b0011, 3'b000} ||
            {arsize, arburst, arlock, arcache, arprot} !== {3'd3, 2'b01, 1'b0, 4'b0011, 3'b000}) begin
            errors++; $display("FAIL const_fields: got aw %h %h %h %h %h ar %h %h %h %h %h required 3 1 0 3 0",
                awsize, awburst, awlock, awcache, awprot, arsize, arburst, arlock, arcache, arprot);
        end
        clear_inputs();
        @(negedge aclk);
    endtask

    task automatic test_write_basic();
        res_t r;
        write_cmd(4'd3, 32'h1000, 8'd3, 4'd3, 2'd0, 0, 1'b0, r);
        checks++;
        if (r.acc_wait != 0 || r.addr_bad != 0) begin
            errors++; $display("FAIL wr_basic_aw: accept wait %0d addr errs %0d required 0 0", r.acc_wait, r.addr_bad);
        end
        checks++;
        if (r.first_cyc != 0) begin
            errors++; $display("FAIL wr_basic_latency: first beat at %0d required 0", r.first_cyc);
        end
        checks++;
        if (r.beats != 4 || r.last_pos != 4 || r.data_bad != 0) begin
            errors++; $display("FAIL wr_basic_beats: beats %0d wlast@%0d data errs %0d required 4 4 0",
                r.beats, r.last_pos, r.data_bad);
        end
        checks++;
        if (r.dones != 1 || r.d_write !== 1'b1 || r.d_id !== 4'd3 || r.d_resp !== 2'd0) begin
            errors++; $display("FAIL wr_basic_done: n=%0d w=%b id=%0d resp=%0d required 1 1 3 0",
                r.dones, r.d_write, r.d_id, r.d_resp);
        end
    endtask

    task automatic test_arbitration();
        bit last_rd, exp_rd;
        int grants, cyc, last_t, gap_exp, bad_order;
        bit is_rd_q[$];
        bit done_q[$];
        areset = 1;
        @(negedge aclk);
        areset = 0;
        wc_valid = 1; wc_id = 1; wc_addr = 32'h40; wc_len = 0;
        rc_valid = 1; rc_id = 2; rc_addr = 32'h80; rc_len = 0;
        awready = 1; arready = 1; wready = 1; wd_valid = 1; bvalid = 1; bid = 1; bresp = 0;
        rvalid = 1; rid = 2; rresp = 0; rlast = 1; rd_ready = 1;
        last_rd = 1; grants = 0; cyc = 0; last_t = 0; gap_exp = 0;
        while (grants < 8 && cyc < 200) begin
            #1;
            if (done_valid) done_q.push_back(done_write);
            if (wc_ready || rc_ready) begin
                exp_rd = !last_rd;
                checks++;
                if (rc_ready !== exp_rd || wc_ready === rc_ready) begin
                    errors++; $display("FAIL arb_order[%0d]: wc_ready=%b rc_ready=%b required read=%b",
                        grants, wc_ready, rc_ready, exp_rd);
                end
                if (grants > 0) begin
                    checks++;
                    if (cyc - last_t != gap_exp) begin
                        errors++; $display("FAIL arb_gap[%0d]: got %0d cycles required %0d", grants, cyc - last_t, gap_exp);
                    end
                end
                // accept, address cycle, one beat, then B (writes only), then the next accept
                gap_exp = 3 + (rc_ready ? 0 : 1);
                last_rd = rc_ready; last_t = cyc; grants++;
                is_rd_q.push_back(rc_ready);
            end
            @(negedge aclk); cyc++;
        end
        wc_valid = 0; rc_valid = 0;
        repeat (8) begin
            #1;
            if (done_valid) done_q.push_back(done_write);
            @(negedge aclk);
        end
        clear_inputs();
        bad_order = 0;
        if (done_q.size() == is_rd_q.size()) begin
            foreach (done_q[i]) if (done_q[i] == is_rd_q[i]) bad_order++;
        end
        checks++;
        if (grants != 8 || done_q.size() != 8 || bad_order != 0) begin
            errors++; $display("FAIL arb_done: grants %0d dones %0d kind errs %0d required 8 8 0",
                grants, done_q.size(), bad_order);
        end
    endtask

    task automatic test_read_resp();
        res_t r;
        logic [1023:0] rv;
        int mx;
        rv = '0;
        rv[2*7 +: 2] = 2'd2;
        mx = 0;
        for (int i = 0; i < 8; i++) if (int'(rv[2*i +: 2]) > mx) mx = int'(rv[2*i +: 2]);
        read_cmd(4'd5, 32'h2000, 8'd7, 4'd5, rv, 8, 0, 1'b1, r);
        checks++;
        if (r.beats != 8 || r.last_pos != 8 || r.data_bad != 0 || r.addr_bad != 0) begin
            errors++; $display("FAIL rd_resp_beats: beats %0d rd_last@%0d errs %0d/%0d required 8 8 0 0",
                r.beats, r.last_pos, r.data_bad, r.addr_bad);
        end
        checks++;
        if (r.dones != 1 || r.d_write !== 1'b0 || r.d_id !== 4'd5 || r.d_resp !== 2'(mx)) begin
            errors++; $display("FAIL rd_resp_done: n=%0d w=%b id=%0d resp=%0d required 1 0 5 %0d",
                r.dones, r.d_write, r.d_id, r.d_resp, mx);
        end
    endtask

    task automatic test_aw_stall();
        res_t r;
        logic [LEN_W-1:0] len;
        len = LEN_W'($urandom_range(1, 15));
        write_cmd(4'd9, 32'hABC0, len, 4'd9, 2'd1, 10, 1'b1, r);
        checks++;
        if (r.addr_bad != 0) begin
            errors++; $display("FAIL aw_stall_hold: %0d bad address-phase cycles required 0", r.addr_bad);
        end
        checks++;
        if (r.beats != int'(len) + 1 || r.last_pos != int'(len) + 1 || r.data_bad != 0) begin
            errors++; $display("FAIL aw_stall_beats: beats %0d wlast@%0d errs %0d required %0d",
                r.beats, r.last_pos, r.data_bad, int'(len) + 1);
        end
        checks++;
        if (r.dones != 1 || r.d_resp !== 2'd1 || r.d_id !== 4'd9) begin
            errors++; $display("FAIL aw_stall_done: n=%0d id=%0d resp=%0d required 1 9 1", r.dones, r.d_id, r.d_resp);
        end
    endtask

    task automatic test_early_rlast_and_id();
        res_t r;
        read_cmd(4'd4, 32'h3000, 8'd3, 4'd4, '0, 2, 0, 1'b0, r);
        checks++;
        if (r.beats != 2 || r.last_pos != 2 || r.dones != 1 || r.d_resp !== 2'd0 || r.d_id !== 4'd4) begin
            errors++; $display("FAIL early_rlast: beats %0d rd_last@%0d dones %0d resp %0d id %0d required 2 2 1 0 4",
                r.beats, r.last_pos, r.dones, r.d_resp, r.d_id);
        end
        write_cmd(4'd2, 32'h3100, 8'd0, 4'd7, 2'd0, 0, 1'b0, r);
        checks++;
        if (r.acc_wait != 0 || r.beats != 1 || r.last_pos != 1) begin
            errors++; $display("FAIL early_rlast_idle: accept wait %0d beats %0d wlast@%0d required 0 1 1",
                r.acc_wait, r.beats, r.last_pos);
        end
        checks++;
        if (r.dones != 1 || r.d_id !== 4'd2 || r.d_resp !== 2'd2) begin
            errors++; $display("FAIL bid_mismatch: n=%0d id=%0d resp=%0d required 1 2 2", r.dones, r.d_id, r.d_resp);
        end
    endtask

    task automatic test_max_len();
        res_t r;
        logic [1023:0] rv;
        write_cmd(4'd1, 32'h8000, 8'd255, 4'd1, 2'd0, 0, 1'b0, r);
        checks++;
        if (r.beats != 256 || r.last_pos != 256 || r.dones != 1) begin
            errors++; $display("FAIL max_len_wr: beats %0d wlast@%0d dones %0d required 256 256 1",
                r.beats, r.last_pos, r.dones);
        end
        rv = '0;
        for (int i = 0; i < 258; i++) rv[2*i +: 2] = 2'd1;
        read_cmd(4'd6, 32'h9000, 8'd255, 4'd6, rv, 258, 0, 1'b0, r);
        checks++;
        if (r.beats != 258 || r.last_pos != 258 || r.dones != 1 || r.d_resp !== 2'd1) begin
            errors++; $display("FAIL overrun_rd: beats %0d rd_last@%0d dones %0d resp %0d required 258 258 1 1",
                r.beats, r.last_pos, r.dones, r.d_resp);
        end
    endtask

    task automatic test_reset_mid_burst();
        res_t r;
        int w, bad, dn;
        accept_cmd(0, 4'd6, 32'h5000, 8'd7, w);
        addr_phase(0, 4'd6, 32'h5000, 8'd7, 0, bad);
        wd_valid = 1; wready = 1;
        repeat (2) @(negedge aclk);
        areset = 1; bvalid = 1; rvalid = 1; rlast = 1; rd_ready = 1;
        #1;
        dn = done_valid ? 1 : 0;
        @(negedge aclk);
        #1;
        if (done_valid) dn++;
        checks++;
        if ({awvalid, arvalid, wvalid, wd_ready, wlast, bready, rready, rd_valid, rd_last, done_valid} !== 10'b0 ||
            {awid, awaddr, awlen} !== '0 || dn != 0) begin
            errors++; $display("FAIL reset_mid: outs %b aw %h/%h/%h dones %0d required all 0",
                {awvalid, arvalid, wvalid, wd_ready, wlast, bready, rready, rd_valid, rd_last, done_valid},
                awid, awaddr, awlen, dn);
        end
        @(negedge aclk);
        clear_inputs();
        areset = 0;
        write_cmd(4'd10, 32'h5100, 8'd1, 4'd10, 2'd0, 0, 1'b0, r);
        checks++;
        if (r.acc_wait != 0 || r.beats != 2 || r.dones != 1 || r.d_id !== 4'd10) begin
            errors++; $display("FAIL reset_restart: wait %0d beats %0d dones %0d id %0d required 0 2 1 10",
                r.acc_wait, r.beats, r.dones, r.d_id);
        end
    endtask

    task automatic test_random();
        res_t r;
        bit is_rd, mism;
        logic [ID_W-1:0] id, rsp_id;
        logic [LEN_W-1:0] len;
        logic [1:0] b_resp, exp_resp;
        logic [1023:0] rv;
        int nb, exp_beats, stall;
        for (int it = 0; it < 12; it++) begin
            is_rd  = 1'($urandom_range(0, 1));
            id     = ID_W'($urandom);
            len    = LEN_W'($urandom_range(0, 7));
            mism   = ($urandom_range(0, 3) == 0);
            rsp_id = mism ? (id ^ ID_W'($urandom_range(1, 15))) : id;
            stall  = $urandom_range(0, 3);
            if (!is_rd) begin
                b_resp = 2'($urandom);
                write_cmd(id, $urandom, len, rsp_id, b_resp, stall, 1'b1, r);
                exp_beats = int'(len) + 1;
                exp_resp  = mism ? 2'd2 : b_resp;
            end else begin
                nb = $urandom_range(1, int'(len) + 3);
                rv = '0;
                exp_resp = 2'd0;
                for (int i = 0; i < nb; i++) begin
                    rv[2*i +: 2] = 2'($urandom);
                    if (rv[2*i +: 2] > exp_resp) exp_resp = rv[2*i +: 2];
                end
                if (mism) exp_resp = 2'd2;
                read_cmd(id, $urandom, len, rsp_id, rv, nb, stall, 1'b1, r);
                exp_beats = nb;
            end
            checks++;
            if (r.beats != exp_beats || r.last_pos != exp_beats) begin
                errors++; $display("FAIL rand_beats[%0d]: beats %0d last@%0d required %0d", it, r.beats, r.last_pos, exp_beats);
            end
            checks++;
            if (r.dones != 1 || r.d_write !== !is_rd || r.d_id !== id || r.d_resp !== exp_resp) begin
                errors++; $display("FAIL rand_done[%0d]: n=%0d w=%b id=%0d resp=%0d required 1 %b %0d %0d",
                    it, r.dones, r.d_write, r.d_id, r.d_resp, !is_rd, id, exp_resp);
            end
            checks++;
            if (r.acc_wait != 0 || r.addr_bad != 0 || r.data_bad != 0) begin
                errors++; $display("FAIL rand_protocol[%0d]: wait %0d addr errs %0d data errs %0d required 0",
                    it, r.acc_wait, r.addr_bad, r.data_bad);
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_basic();
        test_arbitration();
        test_read_resp();
        test_aw_stall();
        test_early_rlast_and_id();
        test_max_len();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
